// File: rtl/riscv_pkg.sv
// Shared constants, types and helpers for the riscv memory (LSU) stage.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_W    = 30;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned BE_W    = 4;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Memory operation held while the bus transaction is outstanding.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [2:0]       width;
        logic             we;
    } lsu_pend_t;

    // Reserved funct3 encodings (011, 110, 111) behave as a full word.
    function automatic mem_size_t mem_size(input logic [2:0] width);
        mem_size_t sz;
        case (width)
            MEM_B, MEM_BU: sz = SZ_BYTE;
            MEM_H, MEM_HU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic misaligned(input logic [2:0] width, input logic [1:0] addr_lo);
        logic mis;
        case (mem_size(width))
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store byte enables/replicated write data, load extract and extend.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  width_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    always_comb begin
        be_o        = 4'b1111;
        st_data_o   = st_data_i;
        ld_data_o   = ld_word_i;
        is_unsigned = width_i[2];
        byte_sel    = ld_word_i[{addr_lo_i, 3'b000} +: 8];
        // Halfword lane follows addr[1] only; addr[0] is ignored here.
        half_sel    = ld_word_i[{addr_lo_i[1], 4'b0000} +: 16];

        case (mem_size(width_i))
            SZ_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = is_unsigned ? {24'h000000, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = is_unsigned ? {16'h0000, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_o      = 4'b1111;
                st_data_o = st_data_i;
                ld_data_o = ld_word_i;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Memory stage: one req/ack data-bus transaction per load/store, registered writeback output.
// Optional misaligned-access trap enabled by defining RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,

    output logic        ready_o,
    input  logic        valid_i,
    input  logic [29:0] pc_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_valid_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_width_i,

    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [29:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,

    input  logic        ready_i,
    output logic        valid_o,
    output logic [29:0] pc_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        fault_o,

    output logic [4:0]  hz_rd_addr_o,
    output logic [31:0] hz_rd_data_o,
    output logic        hz_load_pending_o
);

    lsu_state_t        state_q, state_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              fault_q, fault_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    lsu_pend_t         pend_q, pend_d;

    logic              accept;
    logic              trap;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   ld_data;

    riscv_lsu_align u_align (
        .width_i   (pend_q.width),
        .addr_lo_i (pend_q.addr[1:0]),
        .st_data_i (pend_q.data),
        .ld_word_i (dbus_rdata_i),
        .be_o      (be),
        .st_data_o (wdata),
        .ld_data_o (ld_data)
    );

    assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    assign trap = mem_valid_i && misaligned(mem_width_i, rd_data_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_comb begin : next_state
        state_d = state_q;
        valid_d = valid_q;
        fault_d = fault_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        data_d  = data_q;
        pend_d  = pend_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!mem_valid_i) begin
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                        pc_d    = pc_i;
                        rd_d    = rd_addr_i;
                        data_d  = rd_data_i;
                    end else if (trap) begin
                        // Faulting access bypasses the bus and reports its address.
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        pc_d    = pc_i;
                        rd_d    = '0;
                        data_d  = rd_data_i;
                    end else begin
                        pend_d.pc    = pc_i;
                        pend_d.rd    = mem_we_i ? REG_W'(0) : rd_addr_i;
                        pend_d.addr  = rd_data_i;
                        pend_d.data  = mem_data_i;
                        pend_d.width = mem_width_i;
                        pend_d.we    = mem_we_i;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (req_q && dbus_ack_i) begin
                    valid_d = 1'b1;
                    fault_d = 1'b0;
                    pc_d    = pend_q.pc;
                    rd_d    = pend_q.rd;
                    data_d  = pend_q.we ? pend_q.addr : ld_data;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request only while the output register is empty; it then holds until ack.
        req_d = (state_d == REQ) && !valid_d;
    end

    always_ff @(posedge clk_i) begin : ctrl_regs
        if (reset_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk_i) begin : data_regs
        pc_q   <= pc_d;
        rd_q   <= rd_d;
        data_q <= data_d;
        pend_q <= pend_d;
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = pend_q.we;
    assign dbus_addr_o  = pend_q.addr[31:2];
    assign dbus_be_o    = be;
    assign dbus_wdata_o = wdata;

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign rd_addr_o = rd_q;
    assign rd_data_o = data_q;
    assign fault_o   = fault_q;

    assign hz_rd_addr_o      = (state_q == REQ) ? pend_q.rd : (valid_q ? rd_q : REG_W'(0));
    assign hz_rd_data_o      = valid_q ? data_q : XLEN'(0);
    assign hz_load_pending_o = (state_q == REQ) && !pend_q.we;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed vectors plus a per-cycle reference model.
module tb_riscv_lsu;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    logic        clk;
    logic        reset_i;
    logic        ready_o;
    logic        valid_i;
    logic [29:0] pc_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic [31:0] mem_data_i;
    logic        mem_valid_i;
    logic        mem_we_i;
    logic [2:0]  mem_width_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [29:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        ready_i;
    logic        valid_o;
    logic [29:0] pc_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        fault_o;
    logic [4:0]  hz_rd_addr_o;
    logic [31:0] hz_rd_data_o;
    logic        hz_load_pending_o;

    riscv_lsu dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .ready_o           (ready_o),
        .valid_i           (valid_i),
        .pc_i              (pc_i),
        .rd_addr_i         (rd_addr_i),
        .rd_data_i         (rd_data_i),
        .mem_data_i        (mem_data_i),
        .mem_valid_i       (mem_valid_i),
        .mem_we_i          (mem_we_i),
        .mem_width_i       (mem_width_i),
        .dbus_req_o        (dbus_req_o),
        .dbus_we_o         (dbus_we_o),
        .dbus_addr_o       (dbus_addr_o),
        .dbus_be_o         (dbus_be_o),
        .dbus_wdata_o      (dbus_wdata_o),
        .dbus_ack_i        (dbus_ack_i),
        .dbus_rdata_i      (dbus_rdata_i),
        .ready_i           (ready_i),
        .valid_o           (valid_o),
        .pc_o              (pc_o),
        .rd_addr_o         (rd_addr_o),
        .rd_data_o         (rd_data_o),
        .fault_o           (fault_o),
        .hz_rd_addr_o      (hz_rd_addr_o),
        .hz_rd_data_o      (hz_rd_data_o),
        .hz_load_pending_o (hz_load_pending_o)
    );

    typedef struct {
        logic [29:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fault;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } bus_t;

    exp_t        out_q[$];
    bus_t        bus_q[$];
    int          n_pass;
    int          n_total;
    logic [31:0] mem [256];
    int          ack_delay;
    logic        force_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference rules in plain arithmetic on byte offsets.
    function automatic logic [31:0] m_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v;
        if (w == W_B || w == W_BU) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (w == W_B && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (w == W_H || w == W_HU) begin
            v = (word >> (8 * (a & 32'd2))) & 32'hFFFF;
            if (w == W_H && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] w, input logic [31:0] a);
        if (w == W_B || w == W_BU) return 4'(32'd1 << (a % 4));
        if (w == W_H || w == W_HU) return 4'(32'd3 << (a & 32'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] d);
        if (w == W_B || w == W_BU) return (d & 32'hFF) * 32'h0101_0101;
        if (w == W_H || w == W_HU) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic m_misal(input logic [2:0] w, input logic [31:0] a);
        if (w == W_B || w == W_BU) return 1'b0;
        if (w == W_H || w == W_HU) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Drive one EXU entry (called just after a rising edge) and record what it must produce.
    task automatic issue(input logic [29:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sdata, input logic mv, input logic we, input logic [2:0] w);
        int   g = 0;
        exp_t e;
        bus_t b;
        logic mis;
        valid_i = 1'b1; pc_i = pc; rd_addr_i = rd; rd_data_i = alu;
        mem_data_i = sdata; mem_valid_i = mv; mem_we_i = we; mem_width_i = w;
        @(negedge clk);
        while (!ready_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!ready_o) begin
            chk("accept_timeout", 32'(ready_o), 32'd1);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        mem_valid_i = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        mis = mv && m_misal(w, alu);
`else
        mis = 1'b0;
`endif
        e.pc = pc; e.fault = mis; e.chk_data = 1'b1;
        if (!mv) begin
            e.rd = rd; e.data = alu;
        end else if (mis) begin
            e.rd = 5'd0; e.data = alu;
        end else begin
            b.addr = alu[31:2]; b.we = we; b.be = m_be(w, alu);
            b.wdata = m_wdata(w, sdata); b.rd = we ? 5'd0 : rd;
            bus_q.push_back(b);
            e.rd = we ? 5'd0 : rd;
            e.data = we ? 32'd0 : m_load(w, alu, mem[alu[9:2]]);
            e.chk_data = !we;
        end
        out_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: ack after ack_delay request cycles, or when forced.
    initial begin
        int cnt = 0;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            dbus_ack_i = (dbus_req_o && cnt >= ack_delay) || force_ack;
            if (dbus_req_o) cnt++;
            else cnt = 0;
            dbus_rdata_i = dbus_ack_i ? mem[dbus_addr_o[7:0]] : 32'hDEAD_BEEF;
        end
    end

    // Per-cycle compare against the reference queues.
    initial begin
        logic        p_req, p_ack, p_valid, p_rdy, p_we, p_fault;
        logic [29:0] p_addr, p_pc;
        logic [3:0]  p_be;
        logic [31:0] p_wdata, p_data;
        logic [4:0]  p_rd, hz_exp;
        exp_t        e;
        bus_t        b;
        p_req = 0; p_ack = 0; p_valid = 0; p_rdy = 0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                p_req = 0; p_valid = 0;
            end else begin
                chk("ready_o", 32'(ready_o), 32'(bus_q.size() == 0 && (!valid_o || ready_i)));
                chk("req_valid_excl", 32'(dbus_req_o && valid_o), 32'd0);
                chk("hz_load_pending", 32'(hz_load_pending_o),
                    32'(bus_q.size() != 0 && !bus_q[0].we));
                if (bus_q.size() != 0) hz_exp = bus_q[0].rd;
                else if (valid_o && out_q.size() != 0) hz_exp = out_q[0].rd;
                else hz_exp = 5'd0;
                chk("hz_rd_addr", 32'(hz_rd_addr_o), 32'(hz_exp));

                if (p_req && !p_ack) begin
                    chk("req_hold", 32'(dbus_req_o), 32'd1);
                    chk("req_addr_stable", 32'(dbus_addr_o), 32'(p_addr));
                    chk("req_we_stable", 32'(dbus_we_o), 32'(p_we));
                    chk("req_be_stable", 32'(dbus_be_o), 32'(p_be));
                    chk("req_wdata_stable", dbus_wdata_o, p_wdata);
                end
                if (dbus_req_o) begin
                    if (bus_q.size() == 0) chk("spurious_req", 32'(dbus_req_o), 32'd0);
                    else begin
                        b = bus_q[0];
                        chk("bus_addr", 32'(dbus_addr_o), 32'(b.addr));
                        chk("bus_we", 32'(dbus_we_o), 32'(b.we));
                        if (b.we) begin
                            chk("bus_be", 32'(dbus_be_o), 32'(b.be));
                            chk("bus_wdata", dbus_wdata_o, b.wdata);
                        end
                        if (dbus_ack_i) void'(bus_q.pop_front());
                    end
                end

                if (p_valid && !p_rdy) begin
                    chk("valid_hold", 32'(valid_o), 32'd1);
                    chk("pc_stable", 32'(pc_o), 32'(p_pc));
                    chk("rd_stable", 32'(rd_addr_o), 32'(p_rd));
                    chk("data_stable", rd_data_o, p_data);
                    chk("fault_stable", 32'(fault_o), 32'(p_fault));
                end
                if (valid_o) begin
                    if (out_q.size() == 0) chk("spurious_valid", 32'(valid_o), 32'd0);
                    else begin
                        e = out_q[0];
                        chk("out_pc", 32'(pc_o), 32'(e.pc));
                        chk("out_rd", 32'(rd_addr_o), 32'(e.rd));
                        chk("out_fault", 32'(fault_o), 32'(e.fault));
                        if (e.chk_data) begin
                            chk("out_data", rd_data_o, e.data);
                            chk("hz_rd_data", hz_rd_data_o, e.data);
                        end
                        if (ready_i) void'(out_q.pop_front());
                    end
                end

                p_req = dbus_req_o; p_ack = dbus_ack_i; p_addr = dbus_addr_o; p_we = dbus_we_o;
                p_be = dbus_be_o; p_wdata = dbus_wdata_o;
                p_valid = valid_o; p_rdy = ready_i; p_pc = pc_o; p_rd = rd_addr_o;
                p_data = rd_data_o; p_fault = fault_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h, want 0x%08h", 32'd0, 32'd1);
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        int cyc;
        int reqc;
        n_pass = 0; n_total = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h9E37_79B9;
        mem[8'h40] = 32'h80FF_FF00;
        mem[8'h41] = 32'h8001_7FFE;
        mem[8'h42] = 32'hCAFE_F00D;
        ack_delay = 0; force_ack = 1'b0;
        reset_i = 1'b1; ready_i = 1'b1; valid_i = 1'b0;
        pc_i = '0; rd_addr_i = '0; rd_data_i = '0; mem_data_i = '0;
        mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_width_i = W_W;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(dbus_req_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_hz_rd", 32'(hz_rd_addr_o), 32'd0);
        chk("rst_hz_data", hz_rd_data_o, 32'd0);
        chk("rst_hz_load", 32'(hz_load_pending_o), 32'd0);
        step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);

        // ALU pass-through, one-cycle latency.
        step();
        issue(30'h10, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, W_W);
        @(negedge clk);
        chk("alu_valid", 32'(valid_o), 32'd1);
        chk("alu_data", rd_data_o, 32'h1234);
        chk("alu_rd", 32'(rd_addr_o), 32'd5);

        // LB / LBU from 0x103.
        step();
        issue(30'h11, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, W_B);
        @(negedge clk);
        chk("lb_req", 32'(dbus_req_o), 32'd1);
        chk("lb_addr", 32'(dbus_addr_o), 32'h40);
        chk("lb_not_yet_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("lb_valid", 32'(valid_o), 32'd1);
        chk("lb_data", rd_data_o, 32'hFFFF_FF80);
        step();
        issue(30'h12, 5'd8, 32'h103, 32'h0, 1'b1, 1'b0, W_BU);
        repeat (2) @(negedge clk);
        chk("lbu_data", rd_data_o, 32'h0000_0080);

        // Halfword loads.
        step();
        issue(30'h13, 5'd9, 32'h106, 32'h0, 1'b1, 1'b0, W_H);
        repeat (2) @(negedge clk);
        chk("lh_data", rd_data_o, 32'hFFFF_8001);
        step();
        issue(30'h14, 5'd10, 32'h104, 32'h0, 1'b1, 1'b0, W_HU);
        repeat (2) @(negedge clk);
        chk("lhu_data", rd_data_o, 32'h0000_7FFE);

        // Stores.
        step();
        issue(30'h15, 5'd11, 32'h202, 32'h0000_ABCD, 1'b1, 1'b1, W_H);
        @(negedge clk);
        chk("sh_be", 32'(dbus_be_o), 32'b1100);
        chk("sh_wdata", dbus_wdata_o, 32'hABCD_ABCD);
        chk("sh_we", 32'(dbus_we_o), 32'd1);
        @(negedge clk);
        chk("sh_valid", 32'(valid_o), 32'd1);
        chk("sh_rd", 32'(rd_addr_o), 32'd0);
        step();
        issue(30'h16, 5'd12, 32'h201, 32'h1234_565A, 1'b1, 1'b1, W_B);
        @(negedge clk);
        chk("sb_be", 32'(dbus_be_o), 32'b0010);
        chk("sb_wdata", dbus_wdata_o, 32'h5A5A_5A5A);
        step();
        issue(30'h17, 5'd13, 32'h200, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b111);
        repeat (2) @(negedge clk);

        // Back-to-back ALU ops, a load in between, another ALU op.
        step();
        issue(30'h20, 5'd1, 32'h1111_1111, 32'h0, 1'b0, 1'b0, W_W);
        issue(30'h21, 5'd2, 32'h2222_2222, 32'h0, 1'b0, 1'b0, W_W);
        issue(30'h22, 5'd3, 32'h3333_3333, 32'h0, 1'b0, 1'b0, W_W);
        issue(30'h23, 5'd4, 32'h10C, 32'h0, 1'b1, 1'b0, 3'b011);
        issue(30'h24, 5'd6, 32'h4444_4444, 32'h0, 1'b0, 1'b0, W_W);
        repeat (4) @(negedge clk);

        // Delayed ack with writeback stalled.
        step();
        ready_i = 1'b0;
        ack_delay = 3;
        issue(30'h30, 5'd14, 32'h108, 32'h0, 1'b1, 1'b0, W_W);
        reqc = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            if (dbus_req_o) reqc++;
            cyc++;
        end while (!valid_o && cyc < 50);
        chk("hold_req_cycles", 32'(reqc), 32'd4);
        chk("hold_data", rd_data_o, 32'hCAFE_F00D);
        step();
        @(negedge clk);
        chk("hold_valid_stalled", 32'(valid_o), 32'd1);
        step();
        ready_i = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("hold_consumed", 32'(valid_o), 32'd0);

        // Reset in REQ, then a late ack.
        step();
        ack_delay = 10;
        issue(30'h31, 5'd15, 32'h100, 32'h0, 1'b1, 1'b0, W_W);
        chk("rst_mid_req", 32'(dbus_req_o), 32'd1);
        reset_i = 1'b1;
        out_q.delete();
        bus_q.delete();
        @(negedge clk);
        force_ack = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        force_ack = 1'b0;
        chk("rst_mid_late_ack", 32'(dbus_ack_i), 32'd1);
        @(negedge clk);
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        chk("rst_mid_ready", 32'(ready_o), 32'd1);
        chk("rst_mid_req_low", 32'(dbus_req_o), 32'd0);
        ack_delay = 0;

        // Misaligned word load.
        step();
        issue(30'h32, 5'd4, 32'h102, 32'h0, 1'b1, 1'b0, W_W);
        @(negedge clk);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        chk("mis_req", 32'(dbus_req_o), 32'd0);
        chk("mis_valid", 32'(valid_o), 32'd1);
        chk("mis_fault", 32'(fault_o), 32'd1);
        chk("mis_rd", 32'(rd_addr_o), 32'd0);
        chk("mis_data", rd_data_o, 32'h102);
`else
        chk("mis_req", 32'(dbus_req_o), 32'd1);
        chk("mis_addr", 32'(dbus_addr_o), 32'h40);
        @(negedge clk);
        chk("mis_data", rd_data_o, 32'h80FF_FF00);
        chk("mis_fault", 32'(fault_o), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("out_q_drained", 32'(out_q.size()), 32'd0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
